// File: rtl/npu_fifo_if.sv
// Bus bundle for one npu_fifo instance: write/pop requests in, head word and status out.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface npu_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  we;
    logic                  re;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  almost_full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_data, we, re, clr_err,
        input  rd_data, full, almost_full, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_data, we, re, clr_err,
        output rd_data, full, almost_full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/npu_fifo.sv
// Single-clock first-word-fall-through FIFO between the processor and the NPU,
// with sticky overflow/underflow flags. DEPTH must be a power of two, at least 2.
module npu_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic           clk,
    input  logic           rst_n,
    npu_fifo_if.slave      bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = AF_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_reject;
    logic                  rd_reject;
    logic [ADDR_WIDTH:0]   count;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign count = wr_ptr - rd_ptr;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a paired write.
    assign wr_ok     = bus.we && (!full || bus.re);
    assign rd_ok     = bus.re && !empty;
    assign wr_reject = bus.we && full && !bus.re;
    assign rd_reject = bus.re && empty;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            // A new violation wins over a clear in the same cycle.
            overflow_q  <= wr_reject | (overflow_q  & ~bus.clr_err);
            underflow_q <= rd_reject | (underflow_q & ~bus.clr_err);
        end
    end

    // NOTE: the storage array has no reset; pointers alone define validity, and
    // leaving it unreset lets it map onto plain flops or RAM without reset muxes.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end

    assign bus.rd_data     = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count;
    assign bus.almost_full = (count >= AF_LEVEL);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_npu_fifo.sv
// Directed bench for npu_fifo at DEPTH=4: reset, fill/drain, overflow, underflow,
// full read+write with pointer wrap, and asynchronous reset mid-operation.
module tb_npu_fifo;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    npu_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    npu_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [DW-1:0] d, input logic clr);
        bus.we      = we;
        bus.re      = re;
        bus.wr_data = d;
        bus.clr_err = clr;
    endtask

    task automatic test_reset();
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %0b expected 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %0b expected 0", bus.full); else pass_cnt++;
        total_cnt++; if (bus.almost_full !== 1'b0) $display("FAIL reset_af: got %0b expected 0", bus.almost_full); else pass_cnt++;
        total_cnt++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", bus.count); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %0h expected 0", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", bus.overflow); else pass_cnt++;
        total_cnt++; if (bus.underflow !== 1'b0) $display("FAIL reset_underflow: got %0b expected 0", bus.underflow); else pass_cnt++;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        total_cnt++;
        if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.rd_data !== 32'h0)
            $display("FAIL idle_state: got empty=%0b count=%0d rd_data=%0h expected 1/0/0",
                     bus.empty, bus.count, bus.rd_data);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        logic [2:0] exp_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'hA0 + i, 1'b0);
            tick();
            exp_cnt = 3'(i + 1);
            total_cnt++; if (bus.count !== exp_cnt) $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, exp_cnt); else pass_cnt++;
            total_cnt++; if (bus.almost_full !== (i >= 1)) $display("FAIL fill_af[%0d]: got %0b expected %0b", i, bus.almost_full, (i >= 1)); else pass_cnt++;
            total_cnt++; if (bus.full !== (i == 3)) $display("FAIL fill_full[%0d]: got %0b expected %0b", i, bus.full, (i == 3)); else pass_cnt++;
            total_cnt++; if (bus.rd_data !== 32'hA0) $display("FAIL fill_head[%0d]: got %0h expected a0", i, bus.rd_data); else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            total_cnt++; if (bus.rd_data !== 32'hA0 + i) $display("FAIL drain_data[%0d]: got %0h expected %0h", i, bus.rd_data, 32'hA0 + i); else pass_cnt++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) $display("FAIL drain_empty: got empty=%0b count=%0d expected 1/0", bus.empty, bus.count); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'hB0 + i, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 32'hDEAD, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set: got %0b expected 1", bus.overflow); else pass_cnt++;
        total_cnt++; if (bus.count !== 3'd4 || bus.full !== 1'b1) $display("FAIL ovf_count: got count=%0d full=%0b expected 4/1", bus.count, bus.full); else pass_cnt++;
        total_cnt++; if (bus.underflow !== 1'b0) $display("FAIL ovf_no_unf: got %0b expected 0", bus.underflow); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            total_cnt++; if (bus.rd_data !== 32'hB0 + i) $display("FAIL ovf_drain[%0d]: got %0h expected %0h", i, bus.rd_data, 32'hB0 + i); else pass_cnt++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got empty=%0b ovf=%0b expected 1/1", bus.empty, bus.overflow); else pass_cnt++;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %0b expected 0", bus.overflow); else pass_cnt++;
    endtask

    task automatic test_underflow_rw();
        drive(1'b1, 1'b1, 32'h55, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.underflow !== 1'b1) $display("FAIL unf_set: got %0b expected 1", bus.underflow); else pass_cnt++;
        total_cnt++; if (bus.count !== 3'd1 || bus.empty !== 1'b0) $display("FAIL unf_count: got count=%0d empty=%0b expected 1/0", bus.count, bus.empty); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 32'h55) $display("FAIL unf_data: got %0h expected 55", bus.rd_data); else pass_cnt++;
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        // Underflow again while clearing: the new error must keep the flag set.
        drive(1'b0, 1'b1, 32'h0, 1'b1);
        tick();
        total_cnt++; if (bus.underflow !== 1'b1 || bus.empty !== 1'b1) $display("FAIL unf_set_wins: got unf=%0b empty=%0b expected 1/1", bus.underflow, bus.empty); else pass_cnt++;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.underflow !== 1'b0) $display("FAIL unf_clear: got %0b expected 0", bus.underflow); else pass_cnt++;
    endtask

    task automatic test_full_rw_wrap();
        int bad_full;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h100 + i, 1'b0);
            tick();
        end
        bad_full = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 32'h104 + k, 1'b0);
            total_cnt++; if (bus.rd_data !== 32'h100 + k) $display("FAIL wrap_data[%0d]: got %0h expected %0h", k, bus.rd_data, 32'h100 + k); else pass_cnt++;
            tick();
            if (bus.full !== 1'b1 || bus.count !== 3'd4) bad_full++;
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bad_full !== 0) $display("FAIL wrap_full_held: got %0d cycles not full expected 0", bad_full); else pass_cnt++;
        total_cnt++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) $display("FAIL wrap_flags: got ovf=%0b unf=%0b expected 0/0", bus.overflow, bus.underflow); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h0, 1'b0);
            total_cnt++; if (bus.rd_data !== 32'h114 + i) $display("FAIL wrap_drain[%0d]: got %0h expected %0h", i, bus.rd_data, 32'h114 + i); else pass_cnt++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty: got %0b expected 1", bus.empty); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'hC0 + i, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.count !== 3'd3 || bus.underflow !== 1'b1) $display("FAIL pre_rst: got count=%0d unf=%0b expected 3/1", bus.count, bus.underflow); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.rd_data !== 32'h0 || bus.full !== 1'b0 ||
            bus.underflow !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL async_rst: got empty=%0b count=%0d rd=%0h full=%0b unf=%0b ovf=%0b expected 1/0/0/0/0/0",
                     bus.empty, bus.count, bus.rd_data, bus.full, bus.underflow, bus.overflow);
        else pass_cnt++;
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'hD0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.count !== 3'd1 || bus.rd_data !== 32'hD0) $display("FAIL post_rst_write: got count=%0d rd=%0h expected 1/d0", bus.count, bus.rd_data); else pass_cnt++;
        drive(1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        total_cnt++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) $display("FAIL post_rst_read: got empty=%0b unf=%0b expected 1/0", bus.empty, bus.underflow); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_rw();
        test_full_rw_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/npu_fifo.md
# npu_fifo

Single-clock, first-word-fall-through FIFO that buffers 32-bit words between the processor and the NPU. Three instances sit on the processor's NPU port: input FIFO (processor writes via `npu_input_fifo_we`), config FIFO (processor writes via `npu_config_fifo_we`), and output FIFO (NPU writes, processor pops via `npu_output_fifo_re`). Status outputs drive the processor's `*_full` / `*_empty` inputs directly. Sticky error flags catch protocol violations during bring-up.

## Interface
- `DATA_WIDTH`, 32: word width.
- `DEPTH`, 16: number of entries; must be a power of 2, minimum 2.
- `ADDR_WIDTH`, log2(DEPTH): pointer index width; derived, not overridden.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when `count >= AF_THRESH`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_data` in DATA_WIDTH: write word.
- `we` in 1: write request.
- `re` in 1: read/pop request.
- `clr_err` in 1: synchronous clear of the sticky error flags.
- `rd_data` out DATA_WIDTH: head word, FWFT; 0 when empty.
- `full` out 1: no free entries.
- `almost_full` out 1: `count >= AF_THRESH`.
- `empty` out 1: no stored entries.
- `count` out ADDR_WIDTH+1: occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was dropped.
- `underflow` out 1: sticky; a read hit an empty FIFO.

## Operation
- Storage: register array of DEPTH x DATA_WIDTH. Write and read pointers are ADDR_WIDTH+1 bits. The low bits index the array; the MSB is the wrap bit.
- `empty` = (wr_ptr == rd_ptr). `full` = (index bits equal, wrap bits differ). `count` = wr_ptr − rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write accepted (`wr_ok`) when `we && (!full || re)`:
  - The word is stored at the write index.
  - wr_ptr increments.
- Read accepted (`rd_ok`) when `re && !empty`:
  - rd_ptr increments.
  - The popped word is the `rd_data` value presented during that cycle.
- Simultaneous events:
  - Read+write when neither full nor empty: both accepted; `count` unchanged.
  - Read+write when full: both accepted; the slot freed by the read takes the new word; stays full.
  - Read+write when empty: the write is accepted and the read is rejected (underflow is set). FIFO holds 1 word next cycle; no same-cycle bypass.
- Rejected write (`we && full && !re`): data discarded, pointers unchanged, `overflow` set to 1.
- Rejected read (`re && empty`): pointers unchanged, `underflow` set to 1.
- Sticky flags:
  - Hold until `clr_err` = 1 at a clock edge, or reset.
  - If `clr_err` and a new error occur in the same cycle, the flag is set (set wins).
- Wrap-around: pointers roll over modulo 2^(ADDR_WIDTH+1) with no special handling.
- Reset: asserting `rst_n` low at any time, including mid-transfer, immediately clears pointers, `overflow` and `underflow`. Array contents are not reset.

## Timing
- Reset values: `empty`=1, `full`=0, `almost_full`=0 (given AF_THRESH>0), `count`=0, `rd_data`=0, `overflow`=0, `underflow`=0.
- Write-to-read latency is 1 cycle:
  - A word written at edge N is visible on `rd_data`, with `empty`=0, after edge N.
  - It can be popped at edge N+1.
- `rd_data` is combinational from the array and rd_ptr (FWFT). After a pop at edge N, the next word appears after edge N.
- `full`, `empty`, `almost_full`, `count` are combinational from registered pointers; each is valid the cycle after the causing edge.
- Flags update at the edge of the violating cycle and are visible in the next cycle.
- No combinational path from `we`/`re` to any output.

## Test plan
- Reset then idle (DEPTH=4): `empty`=1, `count`=0, `rd_data`=0; stays so with `we`=`re`=0.
- Fill and drain (DEPTH=4):
  - Write 0xA0..0xA3 on consecutive cycles → `full`=1 and `count`=4 after the 4th edge; `almost_full`=1 from count 2.
  - Pop 4 times → `rd_data` reads 0xA0, 0xA1, 0xA2, 0xA3 in order; then `empty`=1.
- Overflow: with DEPTH=4 full, `we`=1 with 0xDEAD and `re`=0 → `overflow`=1, `count`=4, subsequent drain returns no 0xDEAD. Then `clr_err` pulse → `overflow`=0.
- Underflow and empty read+write: on an empty FIFO, `re`=1 and `we`=1 with 0x55 in the same cycle → `underflow`=1, `count`=1, `rd_data`=0x55 next cycle.
- Full read+write and wrap: with DEPTH=4 full, 20 cycles of simultaneous `re`/`we` with an incrementing pattern → `full` held at 1, `count`=4, no flags set; read order matches write order across multiple pointer wraps.
- Reset mid-operation: with 3 entries stored, pulse `rst_n` low between clock edges → outputs return to reset values immediately and asynchronously; the next write/read behaves as from empty.
